// File: rtl/edge_stream_pkg.sv
// Shared types and defaults for the edge/raw video frame multiplexer.
package edge_stream_pkg;

  localparam int DEF_DATA_W       = 12;
  localparam int DEF_FRAME_PIXELS = 76800;
  localparam int DEF_CNT_W        = 17;

  typedef enum logic [1:0] {
    MODE_SRC0 = 2'b00,
    MODE_SRC1 = 2'b01,
    MODE_ALT  = 2'b10
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Owner of the next frame; the unused 2'b11 encoding falls back to source 0.
  function automatic logic next_src(input logic [1:0] mode, input logic cur);
    case (mode)
      MODE_SRC1: next_src = 1'b1;
      MODE_ALT:  next_src = ~cur;
      default:   next_src = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_stream_out_reg.sv
// Single-entry registered Avalon-ST stage; holds its beat while the sink stalls.
module edge_stream_out_reg
  import edge_stream_pkg::*;
#(
  parameter int W = DEF_DATA_W + 2
) (
  input  logic         clock_clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] in_bits,
  input  logic         m_ready,
  output logic         m_valid,
  output logic [W-1:0] m_bits,
  output logic         advance
);

  assign advance = !m_valid || m_ready;

  always_ff @(posedge clock_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_bits  <= '0;
    end else if (advance) begin
      m_valid <= load;
      if (load) m_bits <= in_bits;
    end
  end

endmodule

// File: rtl/edge_stream_frame_mux.sv
// Frame-boundary arbiter between raw (s0) and edge-scaled (s1) pixel streams.
// state     | meaning
// ST_IDLE   | hunting for sop on cur_src; non-sop beats are dropped
// ST_STREAM | forwarding the current frame from cur_src
module edge_stream_frame_mux
  import edge_stream_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              clock_clk,
  input  logic              reset_n,
  input  logic [1:0]        mode_sel,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_sop,
  input  logic              s0_eop,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_sop,
  input  logic              s1_eop,
  input  logic              s1_valid,
  output logic              s1_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sop,
  output logic              m_eop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              cur_src,
  output logic [15:0]       frame_count,
  output logic              err_short,
  output logic              err_long
);

  localparam logic [CNT_W-1:0] FP_C = CNT_W'(FRAME_PIXELS);

  state_e              state_q, state_d;
  logic                fresh_q;
  logic [CNT_W-1:0]    pix_cnt_q, beat_cnt;
  logic                sel_valid, sel_sop, sel_eop;
  logic [DATA_W-1:0]   sel_data;
  logic                advance, acc, fwd;
  logic                err_short_d, err_long_d;
  logic [DATA_W+1:0]   out_bits;

  // The idle source is always ready so its upstream never stalls.
  assign s0_ready = cur_src ? 1'b1 : advance;
  assign s1_ready = cur_src ? advance : 1'b1;

  always_comb begin
    sel_valid = s0_valid;
    sel_sop   = s0_sop;
    sel_eop   = s0_eop;
    sel_data  = s0_data;
    if (cur_src) begin
      sel_valid = s1_valid;
      sel_sop   = s1_sop;
      sel_eop   = s1_eop;
      sel_data  = s1_data;
    end
  end

  assign acc = sel_valid && advance;

  edge_stream_out_reg #(.W(DATA_W + 2)) u_out_reg (
    .clock_clk (clock_clk),
    .reset_n   (reset_n),
    .load      (fwd),
    .in_bits   ({sel_sop, sel_eop, sel_data}),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_bits    (out_bits),
    .advance   (advance)
  );

  assign {m_sop, m_eop, m_data} = out_bits;

  always_ff @(posedge clock_clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    fwd         = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    beat_cnt    = pix_cnt_q;
    if (sel_sop)               beat_cnt = CNT_W'(1);
    else if (pix_cnt_q != '1)  beat_cnt = pix_cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (acc && sel_sop) begin
          fwd     = 1'b1;
          state_d = sel_eop ? ST_IDLE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (acc) begin
          fwd = 1'b1;
          if (sel_eop) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fwd) begin
      // A sop inside a frame truncates the previous one.
      err_short_d = (state_q == ST_STREAM && sel_sop) || (sel_eop && beat_cnt < FP_C);
      err_long_d  = !sel_sop && (pix_cnt_q == FP_C);
    end
  end

  always_ff @(posedge clock_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt_q   <= '0;
      frame_count <= '0;
      cur_src     <= 1'b0;
      fresh_q     <= 1'b1;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      err_short <= err_short_d;
      err_long  <= err_long_d;
      if (fwd) begin
        pix_cnt_q <= beat_cnt;
        fresh_q   <= 1'b0;
      end
      if (fwd && sel_eop) begin
        frame_count <= frame_count + 16'd1;
        cur_src     <= next_src(mode_sel, cur_src);
      end else if (fresh_q && state_q == ST_IDLE && !fwd) begin
        // Until the first frame starts, the hunt follows the fixed-source modes.
        cur_src <= (mode_sel == MODE_SRC1);
      end
    end
  end

endmodule

// File: tb/tb_edge_stream_frame_mux.sv
// Randomized bench for edge_stream_frame_mux with a frame-level reference model and scoreboard.
module tb_edge_stream_frame_mux;
  localparam int DW = 12;
  localparam int FP = 16;
  localparam int CW = 5;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clock_clk = 1'b0;
  logic reset_n = 1'b1;
  logic [1:0] mode_sel = 2'b00;
  logic [DW-1:0] sd[2];
  logic sv[2], ssop[2], seop[2];
  logic s0_ready, s1_ready;
  logic [DW-1:0] m_data;
  logic m_sop, m_eop, m_valid, cur_src, err_short, err_long;
  logic m_ready = 1'b1;
  logic [15:0] frame_count;

  always #5 clock_clk = ~clock_clk;

  edge_stream_frame_mux #(.DATA_W(DW), .FRAME_PIXELS(FP), .CNT_W(CW)) dut (
    .clock_clk(clock_clk), .reset_n(reset_n), .mode_sel(mode_sel),
    .s0_data(sd[0]), .s0_sop(ssop[0]), .s0_eop(seop[0]), .s0_valid(sv[0]), .s0_ready(s0_ready),
    .s1_data(sd[1]), .s1_sop(ssop[1]), .s1_eop(seop[1]), .s1_valid(sv[1]), .s1_ready(s1_ready),
    .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop), .m_valid(m_valid), .m_ready(m_ready),
    .cur_src(cur_src), .frame_count(frame_count), .err_short(err_short), .err_long(err_long)
  );

  typedef struct packed {logic [DW-1:0] data; logic sop; logic eop;} beat_t;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  beat_t sb[$];

  // reference model: expected visible state of the block
  bit e_valid, e_src, e_in_frame, e_fresh, e_es, e_el;
  beat_t e_beat;
  int e_cnt;
  logic [15:0] e_fc;
  bit e_rdy[2];

  // per-source frame generators
  int gen_pos[2], gen_len[2], gen_lo[2], gen_hi[2], gen_frames[2], gen_const[2], pv[2];
  bit noise[2], from_gen[2];
  int pr = 100;

  // output statistics
  int out_beats, out_idx, cur_idx, es_cnt, el_cnt, es_idx, el_idx, s1_low, mixed;
  int fr_first[$];
  int fr_len[$];
  bit prev_stall;
  beat_t prev_beat, popped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pick(input logic [1:0] mode, input bit cur);
    if (mode == 2'b01) return 1'b1;
    if (mode == 2'b10) return !cur;
    return 1'b0;
  endfunction

  task automatic model_reset();
    e_valid = 0; e_beat = '0; e_src = 0; e_in_frame = 0; e_fresh = 1;
    e_es = 0; e_el = 0; e_cnt = 0; e_fc = '0;
    e_rdy[0] = 1; e_rdy[1] = 1;
    sb.delete();
    prev_stall = 0;
  endtask

  task automatic clear_stats();
    out_beats = 0; out_idx = 0; es_cnt = 0; el_cnt = 0; es_idx = 0; el_idx = 0;
    s1_low = 0; mixed = 0;
    fr_first.delete(); fr_len.delete();
  endtask

  task automatic gen_set(input int k, input int frames, input int lo, input int hi,
                         input int cst, input int p, input int pos);
    gen_frames[k] = frames; gen_lo[k] = lo; gen_hi[k] = hi; gen_const[k] = cst;
    pv[k] = p; gen_len[k] = $urandom_range(hi, lo); gen_pos[k] = pos;
  endtask

  always @(negedge clock_clk) begin
    if (chk_en) begin
      chk("s0_ready", s0_ready, e_rdy[0]);
      chk("s1_ready", s1_ready, e_rdy[1]);
      if (!s1_ready) s1_low++;
      chk("m_valid", m_valid, e_valid);
      if (e_valid) begin
        chk("m_data", m_data, e_beat.data);
        chk("m_sop", m_sop, e_beat.sop);
        chk("m_eop", m_eop, e_beat.eop);
      end
      chk("err_short", err_short, e_es);
      chk("err_long", err_long, e_el);
      chk("cur_src", cur_src, e_src);
      chk("frame_count", frame_count, e_fc);
      if (prev_stall) chk("stall_hold", {m_data, m_sop, m_eop}, prev_beat);
      cur_idx = m_sop ? 1 : out_idx + 1;
      if (err_short) begin es_cnt++; es_idx = cur_idx; end
      if (err_long)  begin el_cnt++; el_idx = cur_idx; end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow actual=%0h expected=none t=%0t", m_data, $time);
        end else begin
          popped = sb.pop_front();
          chk("sb_beat", {m_data, m_sop, m_eop}, popped);
        end
        out_beats++;
        out_idx = cur_idx;
        if (m_sop) fr_first.push_back(int'(m_data));
        else if (fr_first.size() > 0 && int'(m_data) != fr_first[$]) mixed++;
        if (m_eop) fr_len.push_back(cur_idx);
      end
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_data, m_sop, m_eop};
    end
  end

  // One clock cycle: drive sources, predict, advance model past the edge.
  task automatic cycle(input bit rst_mid = 0);
    bit acc[2];
    bit fwd;
    beat_t in;
    int s;
    for (int k = 0; k < 2; k++) begin
      from_gen[k] = 0;
      if (gen_frames[k] != 0) begin
        from_gen[k] = 1;
        sv[k]   = ($urandom_range(99, 0) < pv[k]);
        ssop[k] = (gen_pos[k] == 0);
        seop[k] = (gen_pos[k] == gen_len[k] - 1);
        sd[k]   = (gen_const[k] >= 0) ? DW'(gen_const[k]) : DW'($urandom);
      end else if (noise[k]) begin
        sv[k] = $urandom_range(1, 0); ssop[k] = $urandom_range(1, 0);
        seop[k] = $urandom_range(1, 0); sd[k] = DW'($urandom);
      end else begin
        sv[k] = 0; ssop[k] = 0; seop[k] = 0; sd[k] = '0;
      end
    end
    m_ready = ($urandom_range(99, 0) < pr);
    s = e_src;
    e_rdy[s] = !e_valid || m_ready;
    e_rdy[1-s] = 1;
    for (int k = 0; k < 2; k++) acc[k] = sv[k] && e_rdy[k];
    in = {sd[s], ssop[s], seop[s]};
    fwd = acc[s] && (e_in_frame || in.sop);
    if (rst_mid) begin
      #2;
      reset_n = 0;
      model_reset();
      #1;
      chk("rst_mid_m_valid", m_valid, 0);
      chk("rst_mid_frame_count", frame_count, 0);
      chk_en = 0;
      return;
    end
    @(posedge clock_clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (acc[k] && from_gen[k]) begin
        gen_pos[k]++;
        if (gen_pos[k] == gen_len[k]) begin
          gen_pos[k] = 0;
          if (gen_frames[k] > 0) gen_frames[k]--;
          gen_len[k] = $urandom_range(gen_hi[k], gen_lo[k]);
        end
      end
    end
    e_es = 0; e_el = 0;
    if (!e_valid || m_ready) begin
      e_valid = fwd;
      if (fwd) e_beat = in;
    end
    if (fwd) begin
      sb.push_back(in);
      e_fresh = 0;
      if (in.sop) begin
        if (e_in_frame) e_es = 1;
        e_cnt = 1;
      end else begin
        e_cnt = (e_cnt + 1 > CNT_MAX) ? CNT_MAX : e_cnt + 1;
        if (e_cnt == FP + 1) e_el = 1;
      end
      if (in.eop) begin
        if (e_cnt < FP) e_es = 1;
        e_fc++;
        e_in_frame = 0;
        e_src = pick(mode_sel, e_src);
      end else begin
        e_in_frame = 1;
      end
    end else if (e_fresh && !e_in_frame) begin
      e_src = (mode_sel == 2'b01);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_fc(input int target, input int budget);
    int n = 0;
    while (e_fc != 16'(target) && n < budget) begin cycle(); n++; end
    if (e_fc != 16'(target)) chk("timeout_frames", e_fc, target);
  endtask

  task automatic gens_off();
    gen_frames[0] = 0; gen_frames[1] = 0; noise[0] = 0; noise[1] = 0;
  endtask

  task automatic do_reset();
    chk_en = 0;
    sv[0] = 0; sv[1] = 0;
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clock_clk);
    #1;
    reset_n = 1;
    chk_en = 1;
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      sv[k] = 0; ssop[k] = 0; seop[k] = 0; sd[k] = '0;
      gen_frames[k] = 0; noise[k] = 0; pv[k] = 100; gen_pos[k] = 0; gen_len[k] = FP;
      gen_lo[k] = FP; gen_hi[k] = FP; gen_const[k] = -1;
    end
    model_reset();
    clear_stats();
    #1 reset_n = 0;
    #10;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_sop", m_sop, 0);
    chk("rst_m_eop", m_eop, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_cur_src", cur_src, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_err_short", err_short, 0);
    chk("rst_err_long", err_long, 0);
    chk("rst_s0_ready", s0_ready, 1);
    chk("rst_s1_ready", s1_ready, 1);
    @(posedge clock_clk); #1;
    reset_n = 1;
    chk_en = 1;

    // fixed source 0, noise on source 1
    clear_stats(); mode_sel = 2'b00; pr = 100;
    gen_set(0, 3, FP, FP, -1, 100, 0);
    noise[1] = 1;
    run_until_fc(3, 200);
    gens_off(); idle(4);
    chk("t1_frame_count", frame_count, 3);
    chk("t1_beats", out_beats, 48);
    chk("t1_errs", es_cnt + el_cnt, 0);
    chk("t1_s1_ready_low", s1_low, 0);

    // alternate per frame
    do_reset(); clear_stats(); mode_sel = 2'b10;
    gen_set(0, -1, FP, FP, 'h0A0, 100, 0);
    gen_set(1, -1, FP, FP, 'hF0F, 100, 0);
    run_until_fc(3, 400);
    gens_off(); idle(4);
    chk("t2_nframes", fr_first.size(), 3);
    chk("t2_frame0", fr_first[0], 'h0A0);
    chk("t2_frame1", fr_first[1], 'hF0F);
    chk("t2_frame2", fr_first[2], 'h0A0);
    chk("t2_mixed", mixed, 0);

    // mode change mid-frame takes effect after eop
    do_reset(); clear_stats(); mode_sel = 2'b00;
    gen_set(0, 2, FP, FP, 'h0A0, 100, 0);
    gen_set(1, -1, FP, FP, 'hF0F, 100, 0);
    n = 0;
    while (gen_pos[0] != 5 && n < 60) begin cycle(); n++; end
    mode_sel = 2'b01;
    run_until_fc(2, 200);
    gens_off(); idle(4);
    chk("t3_frame0", fr_first[0], 'h0A0);
    chk("t3_frame1", fr_first[1], 'hF0F);
    chk("t3_len0", fr_len[0], 16);
    chk("t3_len1", fr_len[1], 16);
    chk("t3_mixed", mixed, 0);

    // short and long frames
    do_reset(); clear_stats(); mode_sel = 2'b00; pr = 100;
    gen_set(0, 1, 10, 10, -1, 100, 0); run_until_fc(1, 100);
    gen_set(0, 1, 20, 20, -1, 100, 0); run_until_fc(2, 100);
    gen_set(0, 1, FP, FP, -1, 100, 0); run_until_fc(3, 100);
    gens_off(); idle(4);
    chk("t4_short_cnt", es_cnt, 1);
    chk("t4_short_idx", es_idx, 10);
    chk("t4_long_cnt", el_cnt, 1);
    chk("t4_long_idx", el_idx, 17);
    chk("t4_len1", fr_len[1], 20);

    // randomized backpressure, modes and frame lengths, starting mid-frame
    for (int seg = 0; seg < 3; seg++) begin
      do_reset(); clear_stats();
      mode_sel = 2'($urandom_range(3, 0));
      gen_set(0, -1, 14, 18, -1, 70, $urandom_range(13, 1));
      gen_set(1, -1, 14, 18, -1, 70, $urandom_range(13, 1));
      pr = 50;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(99, 0) < 2) mode_sel = 2'($urandom_range(3, 0));
        cycle();
      end
      gens_off(); pr = 100; idle(20);
      chk("t5_sb_drain", sb.size(), 0);
      chk("t5_progress", (out_beats > 0), 1);
    end

    // asynchronous reset in mid-frame
    do_reset(); clear_stats(); mode_sel = 2'b00; pr = 100;
    gen_set(0, -1, FP, FP, -1, 100, 0);
    n = 0;
    while (gen_pos[0] != 7 && n < 40) begin cycle(); n++; end
    cycle(1);
    repeat (2) @(posedge clock_clk);
    #1;
    reset_n = 1;
    chk_en = 1;
    clear_stats();
    gen_frames[0] = 2;
    run_until_fc(1, 200);
    gens_off(); idle(4);
    chk("t6_frames", fr_len.size(), 1);
    chk("t6_len", fr_len[0], 16);
    chk("t6_beats", out_beats, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
